// File: rtl/katp_periph_pkg.sv
// Shared definitions for the KATP peripheral slice: register map, status bit
// positions and receiver state encodings.
package katp_periph_pkg;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int unsigned ST_NEMPTY = 0;
  localparam int unsigned ST_FULL   = 1;
  localparam int unsigned ST_OVF    = 2;
  localparam int unsigned ST_PERR   = 3;
  localparam int unsigned ST_IE     = 4;
  localparam int unsigned ST_FERR   = 5;

  // Odd parity holds when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{par, data};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Simultaneous push and pop both take
// effect, also when full; a pop on empty is ignored, a push on full without a
// pop is dropped.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when paired with a pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy update; pointers wrap naturally at power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver with scancode FIFO and a 16-bit CPU register window.
module ps2_keyboard
  import katp_periph_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        reset,
  inout  logic [15:0] data_bus,
  input  logic [1:0]  address_bus,
  input  logic        enable,
  input  logic        read,
  input  logic        write,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic        irq
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

  // Synchronisers and clock filter
  logic [1:0]     ps2c_sync_q, ps2d_sync_q;
  logic           filt_q, filt_d, filt_prev_q;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic           fall;
  logic           ps2d;

  // Receiver
  rx_state_e      state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic           push_req, set_perr, set_ferr;

  // FIFO and register interface
  logic           fifo_full, fifo_empty, fifo_pop;
  logic [7:0]     fifo_rd;
  logic [CW-1:0]  fifo_count;
  logic           rd0, rd0_q;
  logic           wr_stat;
  logic           ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d, ie_q, ie_d;
  logic           set_ovf;
  logic [15:0]    rdata;
  logic           unused_wbits;

  assign ps2d        = ps2d_sync_q[1];
  assign fall        = filt_prev_q & ~filt_q;
  assign unused_wbits = ^{data_bus[15:6], data_bus[1:0]};

  // Two-flop synchronisers, idle-high after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps2c_sync_q <= '1;
      ps2d_sync_q <= '1;
    end else begin
      ps2c_sync_q <= {ps2c_sync_q[0], ps2_clk};
      ps2d_sync_q <= {ps2d_sync_q[0], ps2_data};
    end
  end

  // Glitch filter: the level flips only after FILTER_LEN consecutive samples
  // disagreeing with it.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (ps2c_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d = ps2c_sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + FCW'(1);
      end
    end
  end

  // Filtered level, its one-cycle delay for edge detection, and run counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      filt_cnt_q  <= filt_cnt_d;
    end
  end

  // Receiver next state: frame decode on falling edges, plus inactivity abort.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = '0;
    push_req  = 1'b0;
    set_perr  = 1'b0;
    set_ferr  = 1'b0;
    if (fall) begin
      case (state_q)
        RX_IDLE: begin
          if (!ps2d) begin
            state_d   = RX_DATA;
            bit_cnt_d = '0;
          end
        end
        RX_DATA: begin
          shift_d = {ps2d, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
          else bit_cnt_d = bit_cnt_q + 3'd1;
        end
        RX_PARITY: begin
          par_d   = ps2d;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          if (!ps2d) set_ferr = 1'b1;
          else if (!odd_parity_ok(shift_q, par_q)) set_perr = 1'b1;
          else push_req = 1'b1;
          state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (state_q != RX_IDLE) begin
      if (tmo_q == TCW'(TIMEOUT_CYCLES - 1)) begin
        state_d   = RX_IDLE;
        shift_d   = '0;
        bit_cnt_d = '0;
      end else begin
        tmo_d = tmo_q + TCW'(1);
      end
    end
  end

  // Receiver state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RX_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
    end
  end

  // One pop per data-register read strobe, taken on the strobe's first edge.
  assign rd0      = enable & read & (address_bus == REG_DATA);
  assign fifo_pop = rd0 & ~rd0_q;
  assign wr_stat  = enable & write & (address_bus == REG_STATUS);
  assign set_ovf  = push_req & fifo_full & ~fifo_pop;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push_req),
    .pop    (fifo_pop),
    .wr_data(shift_q),
    .rd_data(fifo_rd),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Sticky flags with write-1-to-clear; a same-cycle set overrides the clear.
  always_comb begin
    ie_d   = ie_q;
    ovf_d  = set_ovf  | (ovf_q  & ~(wr_stat & data_bus[ST_OVF]));
    perr_d = set_perr | (perr_q & ~(wr_stat & data_bus[ST_PERR]));
    ferr_d = set_ferr | (ferr_q & ~(wr_stat & data_bus[ST_FERR]));
    if (wr_stat) ie_d = data_bus[ST_IE];
  end

  // Control/status registers, read-edge flop and registered interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie_q   <= 1'b0;
      ovf_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      rd0_q  <= 1'b0;
      irq    <= 1'b0;
    end else begin
      ie_q   <= ie_d;
      ovf_q  <= ovf_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      rd0_q  <= rd0;
      irq    <= ie_q & ~fifo_empty;
    end
  end

  // Read mux over registered state.
  always_comb begin
    rdata = '0;
    case (address_bus)
      REG_DATA: begin
        if (!fifo_empty) rdata = {7'b0, 1'b1, fifo_rd};
      end
      REG_STATUS: begin
        rdata[ST_NEMPTY] = ~fifo_empty;
        rdata[ST_FULL]   = fifo_full;
        rdata[ST_OVF]    = ovf_q;
        rdata[ST_PERR]   = perr_q;
        rdata[ST_IE]     = ie_q;
        rdata[ST_FERR]   = ferr_q;
      end
      REG_COUNT: rdata = 16'(fifo_count);
      default:   rdata = '0;
    endcase
  end

  assign data_bus = (enable & read) ? rdata : 'z;

endmodule

// File: doc/ps2_keyboard.md
PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, meaning scancode FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter FILTER_LEN, default 4, meaning consecutive equal samples needed to accept a new ps2_clk level.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 2000, meaning the number of clk cycles without a falling ps2_clk edge that aborts a frame.
REQ-004 Port clk: input, width 1, system clock, rising-edge active.
REQ-005 Port reset: input, width 1, asynchronous, active-high.
REQ-006 Port data_bus: inout, width 16, shared CPU data bus.
REQ-007 Port address_bus: input, width 2, register select (CPU address bits 1:0).
REQ-008 Port enable: input, width 1, chip select from the board decoder.
REQ-009 Port read: input, width 1, CPU read strobe.
REQ-010 Port write: input, width 1, CPU write strobe.
REQ-011 Port ps2_clk: input, width 1, asynchronous PS/2 clock line.
REQ-012 Port ps2_data: input, width 1, asynchronous PS/2 data line.
REQ-013 Port irq: output, width 1, level interrupt request to one bit of the CPU interrupts vector.

Function
REQ-014 Both PS/2 inputs SHALL pass through 2-flop synchronisers; ps2_clk SHALL then pass a FILTER_LEN-sample glitch filter, and a falling edge SHALL be a 1->0 transition of the filtered level.
REQ-015 Receiver FSM states SHALL be IDLE, DATA, PARITY, STOP, each advanced only on a filtered falling edge.
REQ-016 IDLE->DATA SHALL occur when sampled data is 0 (start bit); a sampled 1 SHALL leave the FSM in IDLE.
REQ-017 DATA SHALL shift 8 bits LSB first, then go to PARITY; PARITY SHALL check odd parity over data+parity bit, then go to STOP.
REQ-018 In STOP, a sampled 1 with good parity SHALL push the byte; bad parity SHALL discard the byte and set sticky PERR; stop bit 0 SHALL discard the byte and set sticky FERR; all three cases SHALL return to IDLE.
REQ-019 In any non-IDLE state, TIMEOUT_CYCLES clk cycles with no falling edge SHALL return the FSM to IDLE, discard the partial byte, and set no flag.
REQ-020 A push into a full FIFO SHALL drop the new byte, leave the contents intact, and set sticky OVF.
REQ-021 Reads SHALL be registered as follows: data_bus SHALL be driven only while enable&read, and SHALL be high-Z otherwise.
REQ-022 Read at address 0 SHALL return {7'b0, valid, head byte}; read data SHALL be 0 with valid=0 when the FIFO is empty.
REQ-023 Read at address 1 (status) SHALL return bit0 not-empty, bit1 full, bit2 OVF, bit3 PERR, bit4 IE, bit5 FERR, all other bits 0.
REQ-024 Read at address 2 SHALL return the FIFO count, zero-extended; address 3 SHALL read 0.
REQ-025 A pop SHALL occur once per read strobe: on the first clk edge where enable&read&address 0 holds and it did not hold the previous cycle, provided the FIFO is non-empty; pop on empty SHALL be ignored.
REQ-026 A push and a pop in the same cycle SHALL both take effect, leaving count unchanged, including when the FIFO is full.
REQ-027 A write to address 1 SHALL load IE from bit4 and clear OVF/PERR/FERR where bits 2/3/5 are 1 (write-1-to-clear); a same-cycle flag set SHALL win over the clear; writes to other addresses SHALL be ignored.
REQ-028 irq SHALL be a registered IE & not-empty, asserted 1 cycle after the push that makes the FIFO non-empty.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be $clog2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-030 Asserting reset SHALL asynchronously set the FSM to IDLE, empty the FIFO, and clear count, OVF, PERR, FERR, IE, irq, the shift register, the timeout counter, and the read-edge flop, with data_bus released to high-Z.
REQ-031 The filtered ps2_clk level and synchronisers SHALL reset to 1 (idle line); a frame in flight at reset SHALL be lost.

Structure
REQ-032 Register addresses, status bit indices and FSM state encodings SHALL reside in shared package katp_periph_pkg.
REQ-033 The FIFO SHALL be a separate sub-module sync_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, count); the receiver FSM and bus interface SHALL stay in ps2_keyboard.

Verification
REQ-034 Send frame 0x1C with odd parity bit 0 -> irq=0 (IE=0); status reads 0x0001; address 0 reads 0x011C; a following status read returns 0x0000.
REQ-035 Write 0x0010 to address 1, then send 0xF0 -> irq rises one cycle after the push; popping it drops irq on the next cycle.
REQ-036 Send 9 frames 0x01..0x09 without reading -> count=8; OVF set; pops return 0x01..0x08 in order.
REQ-037 Send 0x1C with the parity bit flipped -> FIFO stays empty and status bit3=1; writing 0x0008 to address 1 clears it.
REQ-038 Send start + 4 data bits then idle for 2100 cycles, then a clean frame 0x2A -> only 0x2A is received and no error flags are set.
REQ-039 Inject 1-cycle ps2_clk glitches during a frame of 0x55 -> 0x55 is received intact; holding read for 5 cycles on address 0 pops exactly one entry.
